// File: rtl/cnn_pool_ctrl_if.sv
// Stream and control bundle for cnn_pool_ctrl: frame start/config/status plus
// the valid/ready pixel input and pooled-pixel output handshakes.
interface cnn_pool_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM_BITS   = 7
);
  logic                  start_i;
  logic [DIM_BITS-1:0]   cfg_width_i;
  logic [DIM_BITS-1:0]   cfg_height_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  cfg_err_o;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;

  modport slave (
    input  start_i, cfg_width_i, cfg_height_i, in_valid_i, in_data_i, out_ready_i,
    output busy_o, done_o, cfg_err_o, in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output start_i, cfg_width_i, cfg_height_i, in_valid_i, in_data_i, out_ready_i,
    input  busy_o, done_o, cfg_err_o, in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/cnn_pool_ctrl.sv
// Streaming 2x2/stride-2 max-pool scheduler with a one-row line buffer.
// Optional feature macro: CNN_POOL_STALL_CNT_EN adds the stall_cnt_o output-stall counter.
module cnn_pool_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 64,
  parameter int DIM_BITS   = $clog2(MAX_WIDTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cnn_pool_ctrl_if.slave    bus
`ifdef CNN_POOL_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int IDX_BITS = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_r, state_n;
  logic [DIM_BITS-1:0]   col_r, row_r, width_r, height_r;
  logic [DATA_WIDTH-1:0] lb_r [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] prev_r, out_data_r, pool_s;
  logic                  out_valid_r, cfg_err_r;
  logic                  cfg_ok_s, start_acc_s, in_ready_s, accept_s, pop_s, push_s;
  logic                  last_col_s, last_pix_s;
  logic [IDX_BITS-1:0]   col_idx_s, col_pair_s;

  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  // Handshake qualifiers and frame-position decode.
  always_comb begin
    cfg_ok_s    = (bus.cfg_width_i  >= DIM_BITS'(2)) && (bus.cfg_width_i  <= DIM_BITS'(MAX_WIDTH)) &&
                  (bus.cfg_height_i >= DIM_BITS'(2)) && (bus.cfg_height_i <= DIM_BITS'(MAX_WIDTH));
    start_acc_s = bus.start_i && (state_r == ST_IDLE) && cfg_ok_s;
    in_ready_s  = (state_r == ST_RUN) && (!out_valid_r || bus.out_ready_i);
    accept_s    = bus.in_valid_i && in_ready_s;
    pop_s       = out_valid_r && bus.out_ready_i;
    last_col_s  = (col_r == width_r - DIM_BITS'(1));
    last_pix_s  = accept_s && last_col_s && (row_r == height_r - DIM_BITS'(1));
    // Odd row, odd column closes a window; the odd-W tail column has an even index.
    push_s      = accept_s && row_r[0] && col_r[0];
    col_idx_s   = col_r[IDX_BITS-1:0];
    col_pair_s  = col_idx_s - IDX_BITS'(1);
  end

  // Max-pool datapath over the assembled 2x2 window.
  always_comb begin : max_pool
    pool_s = max2(max2(lb_r[col_pair_s], lb_r[col_idx_s]), max2(prev_r, bus.in_data_i));
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= ST_IDLE;
    else       state_r <= state_n;
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE:  if (start_acc_s) state_n = ST_RUN;  else state_n = ST_IDLE;
      ST_RUN:   if (last_pix_s)  state_n = ST_DRAIN; else state_n = ST_RUN;
      ST_DRAIN: if (!out_valid_r) state_n = ST_DONE; else state_n = ST_DRAIN;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Frame geometry latch and row/column counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_r    <= DIM_BITS'(0);
      row_r    <= DIM_BITS'(0);
      width_r  <= DIM_BITS'(0);
      height_r <= DIM_BITS'(0);
    end else if (start_acc_s) begin
      col_r    <= DIM_BITS'(0);
      row_r    <= DIM_BITS'(0);
      width_r  <= bus.cfg_width_i;
      height_r <= bus.cfg_height_i;
    end else if (accept_s) begin
      if (last_col_s) begin
        col_r <= DIM_BITS'(0);
        row_r <= row_r + DIM_BITS'(1);
      end else begin
        col_r <= col_r + DIM_BITS'(1);
      end
    end
  end

  // Line buffer and odd-row left-pixel holder; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (accept_s && !row_r[0]) lb_r[col_idx_s] <= bus.in_data_i;
    if (accept_s && row_r[0] && !col_r[0]) prev_r <= bus.in_data_i;
  end

  // One-entry output register with pass-through on simultaneous pop and push.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_r <= 1'b0;
      out_data_r  <= DATA_WIDTH'(0);
    end else if (push_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= pool_s;
    end else if (pop_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Rejected-start pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cfg_err_r <= 1'b0;
    else       cfg_err_r <= bus.start_i && (state_r == ST_IDLE) && !cfg_ok_s;
  end

`ifdef CNN_POOL_STALL_CNT_EN
  // Saturating count of cycles where a result waits on downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                           stall_cnt_o <= 32'd0;
    else if (start_acc_s)                                stall_cnt_o <= 32'd0;
    else if (out_valid_r && !bus.out_ready_i && (stall_cnt_o != 32'hFFFF_FFFF))
                                                         stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

  assign bus.busy_o      = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign bus.done_o      = (state_r == ST_DONE);
  assign bus.cfg_err_o   = cfg_err_r;
  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = out_valid_r;
  assign bus.out_data_o  = out_data_r;

endmodule

// File: tb/tb_cnn_pool_ctrl.sv
// Self-checking bench for cnn_pool_ctrl: directed frames plus randomized handshakes
// compared against a whole-frame 2x2 max reference computed from stored pixels.
module tb_cnn_pool_ctrl;
  localparam int DW = 8;
  localparam int MW = 64;
  localparam int DB = $clog2(MW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnn_pool_ctrl_if #(.DATA_WIDTH(DW), .DIM_BITS(DB)) bus ();
`ifdef CNN_POOL_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  cnn_pool_ctrl #(.DATA_WIDTH(DW), .MAX_WIDTH(MW), .DIM_BITS(DB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef CNN_POOL_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int pix[$];
  int exp_q[$];
  int got_q[$];
  int accepted;
  int last_pop_cyc;
  int done_cyc;
  bit done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: max of each complete 2x2 block, row-major, partial blocks dropped.
  task automatic gen_expected(input int w, input int h);
    int m;
    exp_q.delete();
    for (int r = 0; r < h / 2; r++)
      for (int c = 0; c < w / 2; c++) begin
        m = pix[(2*r)*w + 2*c];
        if (pix[(2*r)*w + 2*c + 1] > m) m = pix[(2*r)*w + 2*c + 1];
        if (pix[(2*r+1)*w + 2*c] > m) m = pix[(2*r+1)*w + 2*c];
        if (pix[(2*r+1)*w + 2*c + 1] > m) m = pix[(2*r+1)*w + 2*c + 1];
        exp_q.push_back(m);
      end
  endtask

  task automatic start_frame(input int w, input int h);
    bus.cfg_width_i  = DB'(w);
    bus.cfg_height_i = DB'(h);
    bus.start_i      = 1'b1;
    tick();
    bus.start_i      = 1'b0;
    check("start_busy", bus.busy_o, 1);
  endtask

  task automatic stream(input int w, input int h, input int vprob, input int rprob, input int budget);
    int idx = 0;
    int cyc = 0;
    got_q.delete();
    done_seen    = 1'b0;
    last_pop_cyc = -1;
    done_cyc     = -1;
    while ((idx < w * h || !done_seen) && cyc < budget) begin
      bus.in_valid_i  = (idx < w * h) && ($urandom_range(99) < vprob);
      bus.in_data_i   = (idx < w * h) ? DW'(pix[idx]) : DW'(0);
      bus.out_ready_i = ($urandom_range(99) < rprob);
      #2;
      if (bus.in_valid_i && bus.in_ready_o) idx++;
      if (bus.out_valid_o && bus.out_ready_i) begin
        got_q.push_back(int'(bus.out_data_o));
        last_pop_cyc = cyc;
      end
      if (bus.done_o && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      tick();
      cyc++;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    accepted = idx;
    check("frame_done_seen", done_seen, 1);
    check("done_one_cycle", bus.done_o, 0);
    check("idle_after_done", bus.busy_o, 0);
    check("out_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("out_data", (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, exp_q[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_done"}, bus.done_o, 0);
    check({tag, "_cfg_err"}, bus.cfg_err_o, 0);
    check({tag, "_in_ready"}, bus.in_ready_o, 0);
    check({tag, "_out_valid"}, bus.out_valid_o, 0);
    check({tag, "_out_data"}, bus.out_data_o, 0);
  endtask

  initial begin
    int w2px[4];
    w2px[0] = 9; w2px[1] = 3; w2px[2] = 200; w2px[3] = 7;
    bus.start_i = 1'b0; bus.cfg_width_i = '0; bus.cfg_height_i = '0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.out_ready_i = 1'b0;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 4x4 ramp, always ready
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(i);
    start_frame(4, 4);
    gen_expected(4, 4);
    stream(4, 4, 100, 100, 500);
    check("w4_done_after_last_pop", done_cyc - last_pop_cyc, 2);

    // 5x3 odd dimensions
    pix.delete();
    for (int i = 0; i < 15; i++) pix.push_back(i);
    start_frame(5, 3);
    gen_expected(5, 3);
    stream(5, 3, 100, 100, 500);
    check("w5_accepted", accepted, 15);

    // 2x2 with downstream stalled
    start_frame(2, 2);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = DW'(w2px[i]); bus.out_ready_i = 1'b0;
      #2;
      check("w2_in_ready", bus.in_ready_o, 1);
      check("w2_no_early_out", bus.out_valid_o, 0);
      tick();
    end
    bus.in_valid_i = 1'b0;
    check("w2_latency_valid", bus.out_valid_o, 1);
    check("w2_latency_data", bus.out_data_o, 200);
    for (int i = 0; i < 10; i++) begin
      #2;
      check("w2_hold_valid", bus.out_valid_o, 1);
      check("w2_hold_data", bus.out_data_o, 200);
      check("w2_hold_in_ready", bus.in_ready_o, 0);
      tick();
    end
`ifdef CNN_POOL_STALL_CNT_EN
    check("w2_stall_cnt", stall_cnt, 10);
`endif
    bus.out_ready_i = 1'b1;
    #2;
    check("w2_pop_data", bus.out_data_o, 200);
    tick();
    bus.out_ready_i = 1'b0;
    check("w2_popped", bus.out_valid_o, 0);
    begin
      int n = 0;
      while (!bus.done_o && n < 20) begin tick(); n++; end
      check("w2_done", bus.done_o, 1);
      tick();
      check("w2_idle", bus.busy_o, 0);
    end

    // Illegal configs
    bus.cfg_width_i = DB'(1); bus.cfg_height_i = DB'(4); bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("w1_cfg_err", bus.cfg_err_o, 1);
    check("w1_busy", bus.busy_o, 0);
    tick();
    check("w1_cfg_err_pulse", bus.cfg_err_o, 0);
    bus.cfg_width_i = DB'(MW + 1); bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("wmax_cfg_err", bus.cfg_err_o, 1);
    check("wmax_busy", bus.busy_o, 0);
    tick();

    // Reset mid-frame, then a clean frame
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(i);
    start_frame(4, 4);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = DW'(i); bus.out_ready_i = 1'b0;
      tick();
    end
    bus.in_valid_i = 1'b0;
    check("pre_rst_out_valid", bus.out_valid_o, 1);
    rst = 1'b1;
    #2;
    check_all_zero("midrst");
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("post_rst");
    start_frame(4, 4);
    gen_expected(4, 4);
    stream(4, 4, 100, 100, 500);

    // Random data and handshake gaps
    pix.delete();
    for (int i = 0; i < 48; i++) pix.push_back(int'($urandom_range(255)));
    start_frame(8, 6);
    gen_expected(8, 6);
    stream(8, 6, 60, 50, 3000);
    check("rand_accepted", accepted, 48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
